// File: rtl/norm_pkg.sv
// Shared types and helpers for the FP-adder mantissa normaliser.
package norm_pkg;

  // Width of a leading-zero count that must represent 0..w inclusive.
  function automatic int unsigned shw_f(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Largest biased exponent (all ones, the infinity code) for a given width.
  function automatic int unsigned exp_max_f(input int unsigned ew);
    return (32'(1) << ew) - 1;
  endfunction

  localparam int unsigned EW_DEFAULT = 8;
  localparam int unsigned EXP_MAX    = (32'(1) << EW_DEFAULT) - 1;

  // Result classification flags; at most one is set per beat.
  typedef struct packed {
    logic zero;
    logic ovf;
    logic uf;
  } norm_flags_t;

endpackage

// File: rtl/normalizer_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module lzc #(
  parameter int unsigned W = 28
) (
  input  logic [W-1:0]             a_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);

  localparam int unsigned CW = $clog2(W + 1);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/normalizer_pipe.sv
// Two-stage mantissa normaliser: S1 counts leading zeros, S2 shifts,
// adjusts the exponent and classifies zero/overflow/underflow.
// Optional feature macro: NORM_SUBNORMAL_EN selects gradual underflow
// instead of flush-to-zero.
module normalizer_pipe
  import norm_pkg::*;
#(
  parameter int unsigned MW = 28,
  parameter int unsigned EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_m,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_m,
  output logic [EW-1:0] out_exp,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          out_uf
);

  localparam int unsigned SHW  = shw_f(MW);
  localparam int unsigned XW   = EW + 2;
  localparam int unsigned EMAX = (EW == EW_DEFAULT) ? EXP_MAX : exp_max_f(EW);

  // Stage 1 registers
  logic           s1_valid_q, s1_valid_d;
  logic [MW-1:0]  s1_m_q,     s1_m_d;
  logic [EW-1:0]  s1_exp_q,   s1_exp_d;
  logic           s1_sign_q,  s1_sign_d;
  logic [SHW-1:0] s1_lz_q,    s1_lz_d;
  logic [SHW-1:0] lz_c;

  // Stage 2 (output) registers
  logic           out_valid_q, out_valid_d;
  logic [MW-1:0]  out_m_q,     out_m_d;
  logic [EW-1:0]  out_exp_q,   out_exp_d;
  logic           out_sign_q,  out_sign_d;
  norm_flags_t    flags_q,     flags_d;

  logic           s1_adv_c, s2_adv_c;
  logic signed [XW-1:0] e_c;

  lzc #(.W(MW)) u_lzc (
    .a_i   (in_m),
    .cnt_o (lz_c)
  );

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  always_comb begin
    s2_adv_c = !out_valid_q || out_ready;
    s1_adv_c = !s1_valid_q || s2_adv_c;
  end

  assign in_ready = s1_adv_c;

  // Stage 1 capture.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_m_d     = s1_m_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_lz_d    = s1_lz_q;
    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_m_d    = in_m;
        s1_exp_d  = in_exp;
        s1_sign_d = in_sign;
        s1_lz_d   = lz_c;
      end
    end
  end

  // Adjusted exponent, evaluated wide enough to see both overflow and underflow.
  assign e_c = $signed(XW'(s1_exp_q) + XW'(1) - XW'(s1_lz_q));

  // Stage 2 shift, exponent adjust and classification (zero > ovf > uf).
  always_comb begin
    out_valid_d = out_valid_q;
    out_m_d     = out_m_q;
    out_exp_d   = out_exp_q;
    out_sign_d  = out_sign_q;
    flags_d     = flags_q;
    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d = s1_sign_q;
        flags_d    = '0;
        if (s1_lz_q == SHW'(MW)) begin
          out_m_d      = '0;
          out_exp_d    = '0;
          flags_d.zero = 1'b1;
        end else if (e_c >= $signed(XW'(EMAX))) begin
          out_m_d     = '0;
          out_exp_d   = '1;
          flags_d.ovf = 1'b1;
        end else if (e_c < $signed(XW'(1))) begin
          out_exp_d  = '0;
          flags_d.uf = 1'b1;
`ifdef NORM_SUBNORMAL_EN
          out_m_d    = s1_m_q << s1_exp_q;
`else
          out_m_d    = '0;
`endif
        end else begin
          out_m_d   = s1_m_q << s1_lz_q;
          out_exp_d = e_c[EW-1:0];
        end
      end
    end
  end

  // State registers for both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_m_q      <= '0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_lz_q     <= '0;
      out_valid_q <= 1'b0;
      out_m_q     <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_m_q      <= s1_m_d;
      s1_exp_q    <= s1_exp_d;
      s1_sign_q   <= s1_sign_d;
      s1_lz_q     <= s1_lz_d;
      out_valid_q <= out_valid_d;
      out_m_q     <= out_m_d;
      out_exp_q   <= out_exp_d;
      out_sign_q  <= out_sign_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_m     = out_m_q;
  assign out_exp   = out_exp_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = flags_q.zero;
  assign out_ovf   = flags_q.ovf;
  assign out_uf    = flags_q.uf;

endmodule
